// File: rtl/phase_seq.sv
// ============================================================================
// Module   : phase_seq
// Brief    : Multicycle phase sequencer with memory handshake and halt support.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phase_seq #(
  parameter int PHASES    = 4,
  parameter int MEM_PHASE = 2,
  parameter int WAITW     = 4,
  parameter int CNTW      = 32,
  localparam int IW       = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_en,
  input  logic              mem_ack,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PHASES-1:0] curr_phase,
  output logic [IW-1:0]     phase_idx,
  output logic              mem_req,
  output logic              instr_done,
  output logic              halted,
  output logic              timeout,
  output logic [CNTW-1:0]   retire_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_HALT     = 2'd2;
  localparam logic [1:0] S_ERR      = 2'd3;

  localparam logic [IW-1:0]    LAST_PHASE = IW'(PHASES - 1);
  localparam logic [IW-1:0]    MEM_IDX    = IW'(MEM_PHASE);
  // Timeout fires on the edge that would bring the counter to all-ones.
  localparam logic [WAITW-1:0] WAIT_LAST  = WAITW'((2 ** WAITW) - 2);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     phase_q, phase_d;
  logic [PHASES-1:0] onehot_q, onehot_d;
  logic [WAITW-1:0]  wait_q, wait_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      phase_q   <= '0;
      onehot_q  <= PHASES'(1);
      wait_q    <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      onehot_q  <= onehot_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    retire  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush && (phase_q != '0)) begin
          phase_d = '0;
          retire  = 1'b1;
          if (halt_req) state_d = S_HALT;
        end else if (stall) begin
          phase_d = phase_q;
        end else if ((phase_q == '0) && halt_req) begin
          state_d = S_HALT;
        end else if ((phase_q == MEM_IDX) && mem_en) begin
          state_d = S_MEM_WAIT;
        end else if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          retire  = 1'b1;
          if (halt_req) state_d = S_HALT;
        end else begin
          phase_d = phase_q + IW'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = S_RUN;
          if (MEM_IDX == LAST_PHASE) begin
            phase_d = '0;
            retire  = 1'b1;
            if (halt_req) state_d = S_HALT;
          end else begin
            phase_d = phase_q + IW'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    mem_req_d = (state_d == S_MEM_WAIT);
    halted_d  = (state_d == S_HALT);
    timeout_d = timeout_q | (state_d == S_ERR);
    done_d    = retire;
    cnt_d     = cnt_q + CNTW'(retire);
    onehot_d  = PHASES'(1) << phase_d;
    wait_d    = ((state_q == S_MEM_WAIT) && (state_d == S_MEM_WAIT)) ? wait_q + WAITW'(1) : '0;
  end

  assign curr_phase = onehot_q;
  assign phase_idx  = phase_q;
  assign mem_req    = mem_req_q;
  assign instr_done = done_q;
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign retire_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_seq.sv
// ============================================================================
// Module   : tb_phase_seq
// Brief    : Directed self-checking bench for phase_seq (PHASES=4, CNTW=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_phase_seq;

  logic       clk = 1'b0;
  logic       reset, stall, flush, mem_en, mem_ack, halt_req, resume;
  logic [3:0] curr_phase;
  logic [1:0] phase_idx;
  logic       mem_req, instr_done, halted, timeout;
  logic [3:0] retire_cnt;

  int passed = 0;
  int total  = 0;

  phase_seq #(.PHASES(4), .MEM_PHASE(2), .WAITW(4), .CNTW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .mem_en     (mem_en),
    .mem_ack    (mem_ack),
    .halt_req   (halt_req),
    .resume     (resume),
    .curr_phase (curr_phase),
    .phase_idx  (phase_idx),
    .mem_req    (mem_req),
    .instr_done (instr_done),
    .halted     (halted),
    .timeout    (timeout),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase one-hot and index must always agree.
  task automatic chk_phase(input string tag, input int idx);
    chk({tag, "_idx"}, 32'(phase_idx), 32'(idx));
    chk({tag, "_oh"}, 32'(curr_phase), 32'(1 << idx));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_en = 1'b0;
    mem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #22;
    chk_phase("rst_phase", 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_done", 32'(instr_done), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cnt", 32'(retire_cnt), 0);
    reset = 1'b0;

    // Free run: 3 full instructions
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_phase("run_phase", i % 4);
      chk("run_done", 32'(instr_done), 32'(i % 4 == 0));
    end
    chk("run_cnt", 32'(retire_cnt), 3);

    // Stall at phase 1 for 3 cycles
    tick();
    chk_phase("st_enter", 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_phase("st_hold", 1);
    end
    stall = 1'b0;
    tick(); chk_phase("st_rel", 2);
    chk("st_cnt", 32'(retire_cnt), 3);
    tick(); tick();
    chk_phase("st_wrap", 0);
    chk("st_cnt4", 32'(retire_cnt), 4);

    // Memory access acked in the 5th wait cycle
    mem_en = 1'b1;
    tick(); tick();
    chk_phase("mem_p2", 2);
    chk("mem_noreq", 32'(mem_req), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("mem_req_hi", 32'(mem_req), 1);
      chk_phase("mem_hold", 2);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_en = 1'b0;
    chk("mem_req_lo", 32'(mem_req), 0);
    chk_phase("mem_after", 3);
    tick();
    chk_phase("mem_wrap", 0);
    chk("mem_done", 32'(instr_done), 1);
    chk("mem_cnt", 32'(retire_cnt), 5);

    // Flush at phase 1, then flush at phase 0 ignored
    tick();
    flush = 1'b1;
    tick();
    chk_phase("fl_p0", 0);
    chk("fl_done", 32'(instr_done), 1);
    chk("fl_cnt", 32'(retire_cnt), 6);
    tick();
    flush = 1'b0;
    chk_phase("fl_ign", 1);
    chk("fl_ign_done", 32'(instr_done), 0);
    chk("fl_ign_cnt", 32'(retire_cnt), 6);
    tick(); tick(); tick();
    chk("fl_cnt7", 32'(retire_cnt), 7);

    // Halt requested during phase 2, then resume
    tick(); tick();
    chk_phase("h_p2", 2);
    halt_req = 1'b1;
    tick();
    chk("h_not_yet", 32'(halted), 0);
    tick();
    halt_req = 1'b0;
    chk("h_halted", 32'(halted), 1);
    chk_phase("h_p0", 0);
    chk("h_done", 32'(instr_done), 1);
    chk("h_cnt", 32'(retire_cnt), 8);
    tick();
    chk("h_still", 32'(halted), 1);
    chk_phase("h_frozen", 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("h_resumed", 32'(halted), 0);
    chk_phase("h_res_p0", 0);
    tick();
    chk_phase("h_res_p1", 1);

    // Counter wrap (CNTW=4): 8 more retires from 8 -> 0
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 27) chk("wrap_15", 32'(retire_cnt), 15);
    end
    chk("wrap_0", 32'(retire_cnt), 0);
    chk("wrap_done", 32'(instr_done), 1);

    // Memory timeout with no ack
    mem_en = 1'b1;
    tick(); tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1 || i == 15) begin
        chk("to_req_hi", 32'(mem_req), 1);
        chk("to_not_yet", 32'(timeout), 0);
      end
    end
    tick();
    chk("to_flag", 32'(timeout), 1);
    chk("to_req_lo", 32'(mem_req), 0);
    chk_phase("to_frozen", 2);
    mem_ack = 1'b1; flush = 1'b1; resume = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0; resume = 1'b0;
    chk("to_sticky", 32'(timeout), 1);
    chk_phase("to_frozen2", 2);
    reset = 1'b1;
    #1;
    chk("to_rst_flag", 32'(timeout), 0);
    chk_phase("to_rst_phase", 0);
    reset = 1'b0;

    // Async reset in the middle of a memory wait
    tick(); tick(); tick();
    chk("ar_req_hi", 32'(mem_req), 1);
    reset = 1'b1;
    #1;
    chk("ar_req_lo", 32'(mem_req), 0);
    chk("ar_cnt", 32'(retire_cnt), 0);
    mem_en = 1'b0;
    tick();
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
